// File: rtl/pong_ball_engine.sv
// Ball position / score / serve sequencer feeding the VGA renderer's ball word.
// Optional macro BALL_SPEEDUP_EN: each paddle hit raises horizontal speed up to VEL_X_MAX.
module pong_ball_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_SIZE  = 20,
  parameter int PADDLE_W   = 20,
  parameter int PADDLE_H   = 100,
  parameter int PL_X       = 100,
  parameter int PR_X       = 500,
  parameter int VEL_X      = 3,
  parameter int VEL_Y      = 3,
  parameter int VEL_X_MAX  = 8,
  parameter int SCORE_HOLD = 30,
  parameter int WIN_SCORE  = 7
) (
  input  logic        slowclock,
  input  logic        iRST_n,
  input  logic        serve,
  input  logic [11:0] pL_ypos,
  input  logic [11:0] pR_ypos,
  output logic [31:0] ball,
  output logic [3:0]  scoreL,
  output logic [3:0]  scoreR,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ST_SERVE_WAIT = 2'b00,
    ST_PLAY       = 2'b01,
    ST_SCORED     = 2'b10,
    ST_GAME_OVER  = 2'b11
  } state_t;

  // Step width covers both the base speed and the speed-up ceiling.
  localparam int VX_TOP = (VEL_X_MAX > VEL_X) ? VEL_X_MAX : VEL_X;
  localparam int VX_W   = $clog2(VX_TOP + 1);
  localparam int HOLD_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

  localparam logic signed [12:0] X_MISS_S = 13'(SCREEN_W - BALL_SIZE);
  localparam logic signed [12:0] Y_MAX_S  = 13'(SCREEN_H - BALL_SIZE);
  localparam logic signed [12:0] L_EDGE_S = 13'(PL_X + PADDLE_W);
  localparam logic signed [12:0] R_EDGE_S = 13'(PR_X);
  localparam logic signed [12:0] BALL_S   = 13'(BALL_SIZE);
  localparam logic signed [12:0] VEL_Y_S  = 13'(VEL_Y);
  localparam logic signed [12:0] ZERO_S   = 13'sd0;

  localparam logic [12:0] BALL_U  = 13'(BALL_SIZE);
  localparam logic [12:0] PAD_H_U = 13'(PADDLE_H);

  localparam logic [10:0] X_CENTRE = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0] Y_CENTRE = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] X_L_STOP = 11'(PL_X + PADDLE_W);
  localparam logic [10:0] X_R_STOP = 11'(PR_X - BALL_SIZE);
  localparam logic [10:0] X_R_MISS = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_BOTTOM = 11'(SCREEN_H - BALL_SIZE);

  localparam logic [3:0]        WIN_Q     = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);

  state_t              state_q, state_d;
  logic [10:0]         x_q, x_d;
  logic [10:0]         y_q, y_d;
  logic                dx_q, dx_d;
  logic                dy_q, dy_d;
  logic [3:0]          score_l_q, score_l_d;
  logic [3:0]          score_r_q, score_r_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                game_over_q, game_over_d;
  logic [VX_W-1:0]     step_x;

`ifdef BALL_SPEEDUP_EN
  logic [VX_W-1:0]     vx_q, vx_d;
  assign step_x = vx_q;
`else
  assign step_x = VX_W'(VEL_X);
`endif

  logic signed [12:0] x_s, y_s, nx, ny, step_s;
  logic [12:0]        y_u, pl_u, pr_u;
  logic               ov_l, ov_r;
  logic               hit_l, hit_r, miss_l, miss_r;

  // Position arithmetic is done 13-bit signed so stepping past 0 shows up as negative.
  always_comb begin
    x_s    = $signed({2'b00, x_q});
    y_s    = $signed({2'b00, y_q});
    step_s = $signed({{(13 - VX_W){1'b0}}, step_x});
    nx     = dx_q ? (x_s + step_s) : (x_s - step_s);
    ny     = dy_q ? (y_s + VEL_Y_S) : (y_s - VEL_Y_S);

    y_u  = {2'b00, y_q};
    pl_u = {1'b0, pL_ypos};
    pr_u = {1'b0, pR_ypos};
    ov_l = ((y_u + BALL_U) > pl_u) && (y_u < (pl_u + PAD_H_U));
    ov_r = ((y_u + BALL_U) > pr_u) && (y_u < (pr_u + PAD_H_U));

    hit_l  = !dx_q && (x_s >= L_EDGE_S) && (nx < L_EDGE_S) && ov_l;
    hit_r  = dx_q && ((x_s + BALL_S) <= R_EDGE_S) && ((nx + BALL_S) > R_EDGE_S) && ov_r;
    miss_l = !dx_q && (nx <= ZERO_S);
    miss_r = dx_q && (nx >= X_MISS_S);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hold_d      = hold_q;
    game_over_d = game_over_q;
`ifdef BALL_SPEEDUP_EN
    vx_d        = vx_q;
`endif

    case (state_q)
      ST_SERVE_WAIT: begin
        x_d = X_CENTRE;
        y_d = Y_CENTRE;
        if (serve) begin
          state_d = ST_PLAY;
`ifdef BALL_SPEEDUP_EN
          vx_d    = VX_W'(VEL_X);
`endif
        end
      end

      ST_PLAY: begin
        if (dy_q && (ny >= Y_MAX_S)) begin
          y_d  = Y_BOTTOM;
          dy_d = 1'b0;
        end else if (!dy_q && (ny <= ZERO_S)) begin
          y_d  = 11'd0;
          dy_d = 1'b1;
        end else begin
          y_d = ny[10:0];
        end

        // A paddle hit wins over a miss detected in the same tick.
        if (hit_l) begin
          x_d  = X_L_STOP;
          dx_d = 1'b1;
        end else if (hit_r) begin
          x_d  = X_R_STOP;
          dx_d = 1'b0;
        end else if (miss_l) begin
          x_d     = 11'd0;
          state_d = ST_SCORED;
          hold_d  = '0;
          if (score_r_q != WIN_Q) score_r_d = score_r_q + 4'd1;
        end else if (miss_r) begin
          x_d     = X_R_MISS;
          state_d = ST_SCORED;
          hold_d  = '0;
          if (score_l_q != WIN_Q) score_l_d = score_l_q + 4'd1;
        end else begin
          x_d = nx[10:0];
        end

`ifdef BALL_SPEEDUP_EN
        if (hit_l || hit_r) begin
          vx_d = (vx_q >= VX_W'(VEL_X_MAX)) ? VX_W'(VEL_X_MAX) : (vx_q + VX_W'(1));
        end
`endif
      end

      ST_SCORED: begin
        // dx still points at the side that missed, which is where the next serve goes.
        if (hold_q == HOLD_LAST) begin
          x_d = X_CENTRE;
          y_d = Y_CENTRE;
          if ((score_l_q == WIN_Q) || (score_r_q == WIN_Q)) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_SERVE_WAIT;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_GAME_OVER: begin
        x_d         = X_CENTRE;
        y_d         = Y_CENTRE;
        game_over_d = 1'b1;
        if (serve) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          state_d     = ST_SERVE_WAIT;
          game_over_d = 1'b0;
        end
      end

      default: state_d = ST_SERVE_WAIT;
    endcase
  end

  always_ff @(posedge slowclock or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_SERVE_WAIT;
      x_q         <= X_CENTRE;
      y_q         <= Y_CENTRE;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      hold_q      <= '0;
      game_over_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      vx_q        <= VX_W'(VEL_X);
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hold_q      <= hold_d;
      game_over_q <= game_over_d;
`ifdef BALL_SPEEDUP_EN
      vx_q        <= vx_d;
`endif
    end
  end

  assign ball      = {x_q, y_q, dx_q, dy_q, 8'h00};
  assign scoreL    = score_l_q;
  assign scoreR    = score_r_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: a per-tick game model fills a scoreboard
// queue, plus fixed-value checks at the key moments of a rally.
module tb_pong_ball_engine;

  logic        slowclock;
  logic        iRST_n;
  logic        serve;
  logic [11:0] pL_ypos;
  logic [11:0] pR_ypos;
  logic [31:0] ball;
  logic [3:0]  scoreL;
  logic [3:0]  scoreR;
  logic [1:0]  state;
  logic        game_over;

  pong_ball_engine dut (
    .slowclock (slowclock),
    .iRST_n    (iRST_n),
    .serve     (serve),
    .pL_ypos   (pL_ypos),
    .pR_ypos   (pR_ypos),
    .ball      (ball),
    .scoreL    (scoreL),
    .scoreR    (scoreR),
    .state     (state),
    .game_over (game_over)
  );

  initial slowclock = 1'b0;
  always #5 slowclock = ~slowclock;

  typedef struct {
    logic [31:0] ball;
    logic [10:0] status;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference game state
  int mx, my, mdx, mdy, msl, msr, mst, mhold, mgo, mvx, mhits;
  bit mhit_now;

`ifdef BALL_SPEEDUP_EN
  localparam int SPEEDUP = 1;
`else
  localparam int SPEEDUP = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 310; my = 230; mdx = 1; mdy = 1;
    msl = 0; msr = 0; mst = 0; mhold = 0; mgo = 0; mvx = 3;
  endtask

  function automatic logic [31:0] model_ball();
    logic [31:0] b;
    b = {mx[10:0], my[10:0], mdx[0], mdy[0], 8'h00};
    return b;
  endfunction

  task automatic model_step(input bit srv, input int pl, input int pr);
    int nx, ny;
    bit ovl, ovr;
    mhit_now = 0;
    case (mst)
      0: begin
        mx = 310; my = 230;
        if (srv) begin mst = 1; mvx = 3; end
      end
      1: begin
        nx  = (mdx != 0) ? mx + mvx : mx - mvx;
        ny  = (mdy != 0) ? my + 3 : my - 3;
        ovl = (my + 20 > pl) && (my < pl + 100);
        ovr = (my + 20 > pr) && (my < pr + 100);
        if (mdy != 0 && ny >= 460) begin my = 460; mdy = 0; end
        else if (mdy == 0 && ny <= 0) begin my = 0; mdy = 1; end
        else my = ny;
        if (mdx == 0 && mx >= 120 && nx < 120 && ovl) begin
          mx = 120; mdx = 1; mhit_now = 1;
        end else if (mdx != 0 && mx + 20 <= 500 && nx + 20 > 500 && ovr) begin
          mx = 480; mdx = 0; mhit_now = 1;
        end else if (mdx == 0 && nx <= 0) begin
          mx = 0; if (msr < 7) msr++; mst = 2; mhold = 0;
        end else if (mdx != 0 && nx >= 620) begin
          mx = 620; if (msl < 7) msl++; mst = 2; mhold = 0;
        end else begin
          mx = nx;
        end
        if (mhit_now) begin
          mhits++;
          if (SPEEDUP != 0 && mvx < 8) mvx++;
        end
      end
      2: begin
        if (mhold == 29) begin
          mx = 310; my = 230;
          if (msl == 7 || msr == 7) begin mst = 3; mgo = 1; end
          else mst = 0;
        end else begin
          mhold++;
        end
      end
      default: begin
        mx = 310; my = 230; mgo = 1;
        if (srv) begin msl = 0; msr = 0; mst = 0; mgo = 0; end
      end
    endcase
  endtask

  // One slowclock tick: drive on the falling edge, predict, check 1 ns after the rising edge.
  task automatic tick(input logic srv);
    exp_t e;
    @(negedge slowclock);
    serve = srv;
    model_step(srv, int'(pL_ypos), int'(pR_ypos));
    e.ball   = model_ball();
    e.status = {msl[3:0], msr[3:0], mst[1:0], mgo[0]};
    sb_q.push_back(e);
    @(posedge slowclock);
    #1;
    e = sb_q.pop_front();
    check("ball", ball, e.ball);
    check("status", {21'd0, scoreL, scoreR, state, game_over}, {21'd0, e.status});
  endtask

  // Pulls reset between clock edges so the clear must be asynchronous.
  task automatic apply_reset();
    #2 iRST_n = 1'b0;
    #1;
    model_reset();
    check("rst_ball", ball, 32'h26C39B00);
    check("rst_scores", {24'd0, scoreL, scoreR}, 32'd0);
    check("rst_state", {29'd0, game_over, state}, 32'd0);
    #1 iRST_n = 1'b1;
  endtask

  initial begin
    int guard;
    int prevx;
    int dx_obs;
    bit cap_checked;

    iRST_n  = 1'b0;
    serve   = 1'b0;
    pL_ypos = 12'd0;
    pR_ypos = 12'd0;
    model_reset();
    @(posedge slowclock);
    #1;
    apply_reset();

    // Idle in SERVE_WAIT
    repeat (10) tick(1'b0);
    check("idle_ball", ball, 32'h26C39B00);
    check("idle_state", {30'd0, state}, 32'd0);

    // Serve, then first move
    tick(1'b1);
    check("serve_state", {30'd0, state}, 32'd1);
    tick(1'b0);
    check("first_x", {21'd0, ball[31:21]}, 32'd313);
    check("first_y", {21'd0, ball[20:10]}, 32'd233);

    // Right paddle hit
    apply_reset();
    pR_ypos = 12'd350;
    tick(1'b1);
    repeat (57) tick(1'b0);
    check("hitR_x", {21'd0, ball[31:21]}, 32'd480);
    check("hitR_y", {21'd0, ball[20:10]}, 32'd401);
    check("hitR_dx", {31'd0, ball[9]}, 32'd0);
    tick(1'b0);
    check("hitR_next_x", {21'd0, ball[31:21]}, 32'd477);

    // Bottom wall bounce then right miss; serve pulses in SCORED are ignored
    apply_reset();
    pR_ypos = 12'd0;
    tick(1'b1);
    repeat (77) tick(1'b0);
    check("wall_y", {21'd0, ball[20:10]}, 32'd460);
    check("wall_dy", {31'd0, ball[8]}, 32'd0);
    repeat (27) tick(1'b0);
    check("missR_x", {21'd0, ball[31:21]}, 32'd620);
    check("missR_scoreL", {28'd0, scoreL}, 32'd1);
    check("missR_state", {30'd0, state}, 32'd2);
    for (int k = 0; k < 30; k++) tick(k == 5 || k == 20);
    check("hold_state", {30'd0, state}, 32'd0);
    check("hold_centre", {10'd0, ball[31:10]}, {10'd0, 11'd310, 11'd230});
    check("hold_dx", {31'd0, ball[9]}, 32'd1);

    // Asynchronous reset in the middle of a rally
    tick(1'b1);
    repeat (20) tick(1'b0);
    apply_reset();

    // Seven right misses end the game
    pR_ypos = 12'd2000;
    pL_ypos = 12'd2000;
    guard = 0;
    while (mst != 3 && guard < 3000) begin
      tick(mst == 0);
      guard++;
    end
    check("go_scoreL", {28'd0, scoreL}, 32'd7);
    check("go_state", {30'd0, state}, 32'd3);
    check("go_flag", {31'd0, game_over}, 32'd1);
    tick(1'b1);
    check("restart_scores", {24'd0, scoreL, scoreR}, 32'd0);
    check("restart_state", {30'd0, state}, 32'd0);

    // Long rally with both paddles tracking the ball
    mhits = 0;
    cap_checked = 0;
    tick(1'b1);
    for (int k = 0; k < 900; k++) begin
      pL_ypos = (my >= 40) ? 12'(my - 40) : 12'd0;
      pR_ypos = (my >= 40) ? 12'(my - 40) : 12'd0;
      prevx = int'(ball[31:21]);
      tick(1'b0);
`ifdef BALL_SPEEDUP_EN
      if (!cap_checked && mhits >= 6 && !mhit_now && mst == 1) begin
        cap_checked = 1;
        dx_obs = int'(ball[31:21]) - prevx;
        if (dx_obs < 0) dx_obs = -dx_obs;
        check("vx_cap", dx_obs, 32'd8);
      end
`endif
    end
    check("rally_state", {30'd0, state}, 32'd1);
    check("rally_scores", {24'd0, scoreL, scoreR}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
